// File: rtl/uart_pkg.sv
// Shared constants for the UART byte-FIFO writers: ASCII codes, frame length,
// state encoding of the time-report FSM and a digit-to-ASCII helper.
package uart_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN = 7;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_LATCH = 2'd1;
    localparam logic [1:0] ENC_CONV  = 2'd2;
    localparam logic [1:0] ENC_SEND  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ENC_IDLE,
        S_LATCH = ENC_LATCH,
        S_CONV  = ENC_CONV,
        S_SEND  = ENC_SEND
    } state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] n);
        return ASCII_ZERO + {4'd0, n};
    endfunction

endpackage

// File: rtl/time_report_tx_bin2dec99.sv
// Combinational binary-to-BCD for one two-digit field; inputs above 99 saturate to 99.
module bin2dec99 (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    logic [6:0] w_val;

    always_comb begin
        w_val  = (i_bin > 7'd99) ? 7'd99 : i_bin;
        o_tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (w_val >= 7'(i * 10)) o_tens = 4'(i);
        end
        o_ones = 4'(w_val - 7'(o_tens) * 7'd10);
    end

endmodule

// File: rtl/time_report_tx.sv
// Formats the displayed time as "HH<sep>LL\r\n" and pushes it byte-by-byte into
// the UART TX FIFO, on request or on a periodic tick.
module time_report_tx
    import uart_pkg::*;
#(
    parameter int unsigned PERIOD_TICKS = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [6:0] digit_h,
    input  logic [6:0] digit_l,
    input  logic       dot,
    input  logic       fifo_full,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PERIOD_TICKS == 0) ? 0 : PERIOD_TICKS - 1);
    localparam logic [2:0] IDX_DONE = 3'(FRAME_LEN);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             w_trigger;
    logic             r_pending;
    logic             r_overrun;
    logic [2:0]       r_idx;
    logic             w_issue;
    logic [7:0]       w_byte;
    logic             r_wr_en;
    logic [7:0]       r_wr_data;

    logic [6:0]       r_h;
    logic [6:0]       r_l;
    logic             r_dot;
    logic [3:0]       w_tens_h, w_ones_h, w_tens_l, w_ones_l;
    logic [3:0]       r_tens_h, r_ones_h, r_tens_l, r_ones_l;

    bin2dec99 u_conv_h (
        .i_bin  (r_h),
        .o_tens (w_tens_h),
        .o_ones (w_ones_h)
    );

    bin2dec99 u_conv_l (
        .i_bin  (r_l),
        .o_tens (w_tens_l),
        .o_ones (w_ones_l)
    );

    assign w_tick    = (PERIOD_TICKS != 0) && (r_tick_cnt == CNT_LAST);
    assign w_trigger = req | w_tick;

    // The first byte is decided during CONV, before the tens/ones registers are loaded,
    // so it takes the converter output directly; this gives the 3-cycle request latency.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE:  if (w_trigger || r_pending) w_next = S_LATCH;
            S_LATCH: w_next = S_CONV;
            S_CONV: begin
                w_next  = S_SEND;
                w_issue = !fifo_full;
            end
            S_SEND: begin
                if (r_idx == IDX_DONE) w_next = S_IDLE;
                else                   w_issue = !fifo_full;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = ascii_digit((r_state == S_CONV) ? w_tens_h : r_tens_h);
            3'd1:    w_byte = ascii_digit(r_ones_h);
            3'd2:    w_byte = r_dot ? ASCII_DOT : ASCII_COLON;
            3'd3:    w_byte = ascii_digit(r_tens_l);
            3'd4:    w_byte = ascii_digit(r_ones_l);
            3'd5:    w_byte = ASCII_CR;
            3'd6:    w_byte = ASCII_LF;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_idx      <= 3'd0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 8'h00;
        end else begin
            r_state <= w_next;

            if (PERIOD_TICKS == 0 || r_tick_cnt == CNT_LAST) r_tick_cnt <= '0;
            else                                             r_tick_cnt <= r_tick_cnt + CNT_W'(1);

            // Leaving IDLE always consumes the pending request, so clearing it in IDLE is enough.
            if (r_state == S_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_trigger) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end

            r_wr_en <= w_issue;
            if (w_issue) begin
                r_wr_data <= w_byte;
                r_idx     <= r_idx + 3'd1;
            end else if (r_state == S_IDLE) begin
                r_idx <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LATCH) begin
            r_h   <= digit_h;
            r_l   <= digit_l;
            r_dot <= dot;
        end
        if (r_state == S_CONV) begin
            r_tens_h <= w_tens_h;
            r_ones_h <= w_ones_h;
            r_tens_l <= w_tens_l;
            r_ones_l <= w_ones_l;
        end
    end

    assign wr_data = r_wr_data;
    assign wr_en   = r_wr_en;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_time_report_tx.sv
// Bench for time_report_tx: request-driven frames on one instance, periodic
// frames on a second instance with a short period.
module tb_time_report_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req, dot, fifo_full;
    logic [6:0] digit_h, digit_l;
    logic [7:0] wr_data;
    logic       wr_en, busy, overrun;

    logic       rst2, req2, dot2, full2;
    logic [6:0] h2, l2;
    logic [7:0] wr_data2;
    logic       wr_en2, busy2, overrun2;

    time_report_tx #(.PERIOD_TICKS(0)) dut (
        .clk(clk), .reset(reset), .req(req), .digit_h(digit_h), .digit_l(digit_l),
        .dot(dot), .fifo_full(fifo_full), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .overrun(overrun)
    );

    time_report_tx #(.PERIOD_TICKS(20)) dut_per (
        .clk(clk), .reset(rst2), .req(req2), .digit_h(h2), .digit_l(l2),
        .dot(dot2), .fifo_full(full2), .wr_data(wr_data2), .wr_en(wr_en2),
        .busy(busy2), .overrun(overrun2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture written bytes and flag writes that follow a full cycle or occur while idle.
    logic [7:0] cap[$];
    int         capcyc[$];
    int         viol = 0;
    logic       last_full = 1'b0;
    always @(negedge clk) begin
        if (wr_en) begin
            cap.push_back(wr_data);
            capcyc.push_back(cyc);
            if (last_full || !busy) viol <= viol + 1;
        end
        last_full <= fifo_full;
    end

    int         starts2[$];
    logic [7:0] bytes2[$];
    logic       prev_en2 = 1'b0;
    always @(negedge clk) begin
        if (wr_en2 && !prev_en2) starts2.push_back(cyc);
        if (wr_en2 && bytes2.size() < 7) bytes2.push_back(wr_data2);
        prev_en2 <= wr_en2;
    end

    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference frame built straight from the text rules: clamp, decimal split, ASCII.
    task automatic add_frame(input int h, input int l, input bit d, inout logic [7:0] q[$]);
        int hc, lc;
        hc = (h > 99) ? 99 : h;
        lc = (l > 99) ? 99 : l;
        q.push_back(8'(48 + hc / 10));
        q.push_back(8'(48 + hc % 10));
        q.push_back(d ? 8'h2E : 8'h3A);
        q.push_back(8'(48 + lc / 10));
        q.push_back(8'(48 + lc % 10));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    function automatic int cc(input int i);
        return (i < capcyc.size()) ? capcyc[i] : -1000;
    endfunction

    task automatic cmp_frames(input string tag);
        chk({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < cap.size()) ? {24'd0, cap[i]} : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap.delete();
        capcyc.delete();
        exp_q.delete();
    endtask

    task automatic pulse_req(output int t);
        req = 1'b1;
        t = cyc;
        step();
        req = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget, input string tag);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, (cap.size() >= n), 1);
    endtask

    int t0, rel2, k;
    logic [7:0] exp2[$];

    initial begin
        reset = 1'b1; req = 1'b0; dot = 1'b0; fifo_full = 1'b0;
        digit_h = 7'd0; digit_l = 7'd0;
        rst2 = 1'b1; req2 = 1'b0; dot2 = 1'b0; full2 = 1'b0; h2 = 7'd42; l2 = 7'd5;
        repeat (3) step();

        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        reset = 1'b0;
        rst2  = 1'b0;
        rel2  = cyc;

        // PERIOD_TICKS=0: no spontaneous frames
        repeat (60) step();
        chk("no_periodic_p0", cap.size(), 0);

        // Basic frame; inputs change after latching and must not leak in
        clear_caps();
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b0;
        add_frame(12, 34, 0, exp_q);
        pulse_req(t0);
        step();
        digit_h = 7'd55; digit_l = 7'd66; dot = 1'b1;
        wait_caps(7, 30, "basic");
        repeat (3) step();
        chk("basic_latency", cc(0), t0 + 3);
        chk("basic_contig", cc(6) - cc(0), 6);
        cmp_frames("basic");
        chk("basic_idle_busy", busy, 0);

        // Separator and clamp
        clear_caps();
        digit_h = 7'd7; digit_l = 7'd120; dot = 1'b1;
        add_frame(7, 120, 1, exp_q);
        pulse_req(t0);
        wait_caps(7, 30, "clamp");
        repeat (3) step();
        cmp_frames("clamp");

        // Backpressure: 5 full cycles right after the 2nd byte
        clear_caps();
        digit_h = 7'd58; digit_l = 7'd9; dot = 1'b0;
        add_frame(58, 9, 0, exp_q);
        pulse_req(t0);
        wait_caps(2, 30, "bp_first2");
        fifo_full = 1'b1;
        repeat (5) step();
        fifo_full = 1'b0;
        wait_caps(7, 40, "bp");
        repeat (5) step();
        cmp_frames("bp");
        chk("bp_stall_gap", cc(3) - cc(2), 6);
        chk("bp_viol", viol, 0);

        // Randomized frames with random backpressure
        for (int it = 0; it < 6; it++) begin
            clear_caps();
            digit_h = 7'($urandom_range(0, 127));
            digit_l = 7'($urandom_range(0, 127));
            dot     = 1'($urandom_range(0, 1));
            add_frame(int'(digit_h), int'(digit_l), dot, exp_q);
            pulse_req(t0);
            k = 0;
            while ((cap.size() < 7 || busy) && k < 80) begin
                fifo_full = ($urandom_range(0, 3) == 0);
                step();
                k++;
            end
            fifo_full = 1'b0;
            chk($sformatf("rnd%0d_timeout", it), (k < 80), 1);
            repeat (3) step();
            cmp_frames($sformatf("rnd%0d", it));
        end
        chk("rnd_viol", viol, 0);

        // Pending and overrun
        clear_caps();
        digit_h = 7'd21; digit_l = 7'd43; dot = 1'b0;
        add_frame(21, 43, 0, exp_q);
        add_frame(99, 0, 1, exp_q);
        pulse_req(t0);
        wait_caps(2, 30, "pend_a");
        pulse_req(t0);
        chk("pend_no_overrun", overrun, 0);
        wait_caps(4, 30, "pend_b");
        pulse_req(t0);
        digit_h = 7'd99; digit_l = 7'd0; dot = 1'b1;
        wait_caps(14, 60, "pend");
        repeat (8) step();
        chk("pend_overrun", overrun, 1);
        chk("pend_gap", cc(7) - cc(6), 4);
        chk("pend_busy", busy, 0);
        cmp_frames("pend");

        // Reset mid-frame after the 3rd byte
        clear_caps();
        digit_h = 7'd3; digit_l = 7'd4; dot = 1'b0;
        pulse_req(t0);
        k = 0;
        while (cap.size() < 3 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rstmid_reach3", cap.size(), 3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_overrun", overrun, 0);
        reset = 1'b0;
        repeat (12) step();
        chk("rstmid_no_more", cap.size(), 3);
        clear_caps();
        digit_h = 7'd88; digit_l = 7'd17; dot = 1'b1;
        add_frame(88, 17, 1, exp_q);
        pulse_req(t0);
        wait_caps(7, 30, "rstmid_next");
        repeat (3) step();
        chk("rstmid_latency", cc(0), t0 + 3);
        cmp_frames("rstmid_next");

        // Periodic instance: first frame 22 cycles after reset release, then every 20
        chk("per_count", (starts2.size() >= 3), 1);
        chk("per_first", (starts2.size() > 0) ? starts2[0] : -1, rel2 + 22);
        for (int i = 1; i < starts2.size(); i++)
            chk($sformatf("per_gap%0d", i), starts2[i] - starts2[i-1], 20);
        add_frame(42, 5, 0, exp2);
        chk("per_len", bytes2.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("per_b%0d", i), (i < bytes2.size()) ? {24'd0, bytes2[i]} : 32'hFFFF_FFFF, exp2[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
